bcd_binary: RTL and testbench
=============================

// Module: bcd_binary
// PURPOSE
//  Sequential BCD-to-binary converter using reverse double-dabble (shift right, subtract 3).
//  Packed BCD digits in, unsigned binary out, with a start/valid handshake.
//  Companion to the binary->BCD converter in the 7-segment display path.
//  Converts keypad/UART-entered decimal values back to binary for arithmetic.
// PARAMETERS
//  DIGITS  7   number of BCD digits on bcd_in; iterations N = 4*DIGITS
//  BIN_W   32  width of binary_out; must be >= 4*DIGITS; result zero-extended
// PORTS
//  clk         in   1           clock, all logic on posedge
//  reset_n     in   1           synchronous, active-low reset
//  start       in   1           request a conversion; sampled only in IDLE or DONE
//  bcd_in      in   4*DIGITS    packed BCD, digit 0 in [3:0]; sampled on the accepted start edge
//  busy        out  1           high in SHIFT or ADJ
//  valid       out  1           high in DONE; binary_out is valid while high
//  binary_out  out  BIN_W       registered result
//  err         out  1           only with BCD_CHECK_EN; see CONFIGURATION
// BEHAVIOUR
//  Reset (reset_n=0 at posedge) -> state IDLE; busy=0, valid=0, binary_out=0, err=0.
//   Counter and work registers also cleared.
//   Applies in any state, including mid-conversion; the partial result is discarded.
//  FSM states: IDLE, SHIFT, ADJ, DONE. busy/valid are decoded from state.
//  IDLE: start=1 -> load work_bcd<=bcd_in, work_bin<=0, cnt<=0; -> SHIFT. Else stay.
//  SHIFT: {work_bcd,work_bin[4*DIGITS-1:0]} <= that vector >> 1 (zero enters MSB); cnt<=cnt+1; -> ADJ.
//  ADJ: for each digit d of work_bcd, if d>=8 then d<=d-3 (4-bit, all digits in parallel).
//   If cnt==4*DIGITS: binary_out<=zero-extended work_bin; -> DONE. Else -> SHIFT.
//  DONE: valid=1; binary_out held. start=1 -> reload as in IDLE, -> SHIFT, valid drops next cycle.
//   Otherwise stay in DONE indefinitely (no auto-return to IDLE).
//  start while busy=1: ignored; no restart, no queueing.
//  Latency: valid rises 2*4*DIGITS clock edges after the edge that accepted start (56 at defaults).
//   Exactly one SHIFT+ADJ pair per bit.
//  binary_out changes only on entry to DONE or on reset; it keeps the old value during a new conversion.
//  Widths: counter wide enough for 4*DIGITS; adjust arithmetic is per-nibble 4-bit, no inter-digit carry.
//   After N iterations work_bcd is all zero for legal input.
//  Input with a nibble >9 (no check compiled): result unspecified, FSM timing unchanged.
// CONFIGURATION
//  BCD_CHECK_EN defined:
//   - err port exists.
//   - On the accepted start edge, if any nibble of bcd_in >9: -> DONE directly
//     (valid on the next cycle, latency 1), binary_out<=0, err<=1.
//   - Otherwise err<=0 and normal conversion.
//   - err is held with valid and cleared on the next accepted start or on reset.
//  BCD_CHECK_EN undefined: no err port, no checking logic; every start takes full latency.
// TESTING
//  1. bcd_in=28'h0000000, start pulse -> valid at edge +56, binary_out=0, busy high edges +1..+55.
//  2. bcd_in=28'h9999999 -> binary_out=32'h0098967F (9999999) with valid.
//  3. bcd_in=28'h1234567 -> 32'h0012D687; then start in DONE with 28'h0000001 -> valid low next cycle, result 1 at +56.
//  4. start re-pulsed at edges +10 and +30 with different bcd_in -> ignored; first result unchanged, valid still at +56.
//  5. reset_n low at edge +20 -> IDLE; busy=0, valid=0, binary_out=0. A new start then converts normally.
//  6. (BCD_CHECK_EN) bcd_in=28'h00000A0 -> valid+err next cycle, binary_out=0. Then 28'h0000042 -> err=0, result 42.

Source files
------------

// File: rtl/bcd_binary.sv
// Sequential BCD-to-binary converter (reverse double-dabble: shift right, subtract 3 from digits >= 8).
// Optional input validation is compiled in with the BCD_CHECK_EN macro, which also adds the err port.
module bcd_binary #(
  parameter int DIGITS = 7,
  parameter int BIN_W  = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic                  busy,
  output logic                  valid,
  output logic [BIN_W-1:0]      binary_out
`ifdef BCD_CHECK_EN
  ,
  output logic                  err
`endif
);

  localparam int N     = 4 * DIGITS;
  localparam int CNT_W = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    ADJ   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [N-1:0]       work_bcd_q, work_bcd_d;
  logic [N-1:0]       work_bin_q, work_bin_d;
  logic [BIN_W-1:0]   binary_out_q, binary_out_d;
  logic [2*N-1:0]     shifted;
`ifdef BCD_CHECK_EN
  logic               err_q, err_d;
`endif

  // A digit that reached 8..15 after a right shift held 16..31 halves; -3 restores the decimal weight.
  function automatic logic [N-1:0] adjust_digits(input logic [N-1:0] v);
    logic [N-1:0] r;
    r = v;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i+3]) r[4*i +: 4] = v[4*i +: 4] - 4'd3;
    end
    return r;
  endfunction

`ifdef BCD_CHECK_EN
  function automatic logic has_bad_digit(input logic [N-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i+3] && (v[4*i+2] || v[4*i+1])) bad = 1'b1;
    end
    return bad;
  endfunction
`endif

  assign shifted = {work_bcd_q, work_bin_q} >> 1;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    work_bcd_d   = work_bcd_q;
    work_bin_d   = work_bin_q;
    binary_out_d = binary_out_q;
`ifdef BCD_CHECK_EN
    err_d        = err_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          work_bcd_d = bcd_in;
          work_bin_d = '0;
          cnt_d      = '0;
          state_d    = SHIFT;
`ifdef BCD_CHECK_EN
          err_d = 1'b0;
          if (has_bad_digit(bcd_in)) begin
            binary_out_d = '0;
            err_d        = 1'b1;
            state_d      = DONE;
          end
`endif
        end
      end
      SHIFT: begin
        work_bcd_d = shifted[2*N-1:N];
        work_bin_d = shifted[N-1:0];
        cnt_d      = cnt_q + CNT_W'(1);
        state_d    = ADJ;
      end
      ADJ: begin
        work_bcd_d = adjust_digits(work_bcd_q);
        if (cnt_q == CNT_W'(N)) begin
          binary_out_d = BIN_W'(work_bin_q);
          state_d      = DONE;
        end else begin
          state_d = SHIFT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      work_bcd_q   <= '0;
      work_bin_q   <= '0;
      binary_out_q <= '0;
`ifdef BCD_CHECK_EN
      err_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      work_bcd_q   <= work_bcd_d;
      work_bin_q   <= work_bin_d;
      binary_out_q <= binary_out_d;
`ifdef BCD_CHECK_EN
      err_q        <= err_d;
`endif
    end
  end

  assign busy       = (state_q == SHIFT) || (state_q == ADJ);
  assign valid      = (state_q == DONE);
  assign binary_out = binary_out_q;
`ifdef BCD_CHECK_EN
  assign err        = err_q;
`endif

endmodule

// File: tb/tb_bcd_binary.sv
// Directed bench for bcd_binary: table of BCD/binary pairs plus hand-written handshake,
// restart, ignored-start and mid-conversion reset sequences (and BCD_CHECK_EN error cases).
module tb_bcd_binary;

  localparam int DIGITS = 7;
  localparam int BIN_W  = 32;
  localparam int LAT    = 2 * 4 * DIGITS;

  logic                clk;
  logic                reset_n;
  logic                start;
  logic [4*DIGITS-1:0] bcd_in;
  logic                busy;
  logic                valid;
  logic [BIN_W-1:0]    binary_out;
`ifdef BCD_CHECK_EN
  logic                err;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  bcd_binary #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .bcd_in     (bcd_in),
    .busy       (busy),
    .valid      (valid),
    .binary_out (binary_out)
`ifdef BCD_CHECK_EN
    ,
    .err        (err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4*DIGITS-1:0] bcd;
    logic [BIN_W-1:0]    bin;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive start for exactly one edge; returns #1 after the accepting edge.
  task automatic apply_start(input logic [4*DIGITS-1:0] bcd);
    @(negedge clk);
    bcd_in = bcd;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Counts edges after the accepting edge until valid; counts cycles where busy was not high.
  task automatic wait_valid(output int lat, output int busy_low);
    lat      = 0;
    busy_low = (busy !== 1'b1) ? 1 : 0;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk);
      #1;
      lat = k;
      if (valid === 1'b1) break;
      if (busy !== 1'b1) busy_low++;
    end
  endtask

  initial begin
    int lat;
    int busy_low;

    vecs[0]  = '{28'h0000000, 32'h00000000};
    vecs[1]  = '{28'h9999999, 32'h0098967F};
    vecs[2]  = '{28'h1234567, 32'h0012D687};
    vecs[3]  = '{28'h0000042, 32'h0000002A};
    vecs[4]  = '{28'h0000001, 32'h00000001};
    vecs[5]  = '{28'h0000010, 32'h0000000A};
    vecs[6]  = '{28'h0000099, 32'h00000063};
    vecs[7]  = '{28'h5000000, 32'h004C4B40};
    vecs[8]  = '{28'h0000008, 32'h00000008};
    vecs[9]  = '{28'h1000000, 32'h000F4240};
    vecs[10] = '{28'h0000009, 32'h00000009};
    vecs[11] = '{28'h0087654, 32'h00015666};

    reset_n = 1'b0;
    start   = 1'b0;
    bcd_in  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_valid", 64'(valid), 64'd0);
    check("reset_binary_out", 64'(binary_out), 64'd0);
`ifdef BCD_CHECK_EN
    check("reset_err", 64'(err), 64'd0);
`endif
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("idle_no_start_valid", 64'(valid), 64'd0);

    for (int i = 0; i < 12; i++) begin
      apply_start(vecs[i].bcd);
      wait_valid(lat, busy_low);
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'(LAT));
      check($sformatf("vec%0d_busy_low_cycles", i), 64'(busy_low), 64'd0);
      check($sformatf("vec%0d_binary_out", i), 64'(binary_out), 64'(vecs[i].bin));
`ifdef BCD_CHECK_EN
      check($sformatf("vec%0d_err", i), 64'(err), 64'd0);
`endif
    end

    // DONE holds indefinitely while start stays low.
    repeat (5) @(posedge clk);
    #1;
    check("done_hold_valid", 64'(valid), 64'd1);
    check("done_hold_busy", 64'(busy), 64'd0);
    check("done_hold_binary_out", 64'(binary_out), 64'h00015666);

    // Restart from DONE: valid drops next cycle, old result held until new one lands.
    apply_start(28'h1234567);
    wait_valid(lat, busy_low);
    check("seq3_first_binary_out", 64'(binary_out), 64'h0012D687);
    apply_start(28'h0000001);
    check("seq3_restart_valid_low", 64'(valid), 64'd0);
    check("seq3_restart_busy", 64'(busy), 64'd1);
    check("seq3_old_result_held", 64'(binary_out), 64'h0012D687);
    wait_valid(lat, busy_low);
    check("seq3_latency", 64'(lat), 64'(LAT));
    check("seq3_binary_out", 64'(binary_out), 64'd1);

    // start re-pulsed at +10 and +30 while busy is ignored.
    apply_start(28'h0000123);
    lat = 200;
    for (int k = 1; k <= 200; k++) begin
      if (k == 10 || k == 30) begin
        start  = 1'b1;
        bcd_in = (k == 10) ? 28'h9999999 : 28'h0000777;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      if (valid === 1'b1) begin
        lat = k;
        break;
      end
    end
    start = 1'b0;
    check("seq4_latency", 64'(lat), 64'(LAT));
    check("seq4_binary_out", 64'(binary_out), 64'h0000007B);

    // Reset at +20 discards the conversion and clears the output.
    apply_start(28'h9999999);
    for (int k = 1; k < 20; k++) begin
      @(posedge clk);
      #1;
    end
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    check("seq5_reset_busy", 64'(busy), 64'd0);
    check("seq5_reset_valid", 64'(valid), 64'd0);
    check("seq5_reset_binary_out", 64'(binary_out), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    check("seq5_idle_after_reset_busy", 64'(busy), 64'd0);
    apply_start(28'h0000042);
    wait_valid(lat, busy_low);
    check("seq5_latency", 64'(lat), 64'(LAT));
    check("seq5_binary_out", 64'(binary_out), 64'h0000002A);

`ifdef BCD_CHECK_EN
    // Illegal digit: straight to DONE with err, then a legal start clears err.
    apply_start(28'h00000A0);
    check("seq6_bad_valid", 64'(valid), 64'd1);
    check("seq6_bad_err", 64'(err), 64'd1);
    check("seq6_bad_binary_out", 64'(binary_out), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    check("seq6_err_held", 64'(err), 64'd1);
    apply_start(28'h0000042);
    check("seq6_err_cleared", 64'(err), 64'd0);
    check("seq6_valid_low", 64'(valid), 64'd0);
    wait_valid(lat, busy_low);
    check("seq6_latency", 64'(lat), 64'(LAT));
    check("seq6_binary_out", 64'(binary_out), 64'h0000002A);
    check("seq6_err_final", 64'(err), 64'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
